// File: rtl/digit_scan_ctrl_if.sv
// Load handshake and display bus for digit_scan_ctrl.
// master = load source / observer side, slave = scan controller side.
interface digit_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load_valid_i;
    logic                  load_ready_o;
    logic [4*DIGITS-1:0]   load_data_i;
    logic [3:0]            bcd_o;
    logic [DIGITS-1:0]     dig_sel_o;
    logic                  frame_o;
    logic                  err_o;

    modport master (
        output load_valid_i, load_data_i,
        input  load_ready_o, bcd_o, dig_sel_o, frame_o, err_o
    );

    modport slave (
        input  load_valid_i, load_data_i,
        output load_ready_o, bcd_o, dig_sel_o, frame_o, err_o
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with frame-aligned value commit.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits, digit 0 always lit).
module digit_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DWELL  = 50000,
    parameter int unsigned GAP    = 500
) (
    input logic              clk_i,
    input logic              rst_n_i,
    digit_scan_ctrl_if.slave bus
);
    localparam int unsigned DW      = 4 * DIGITS;
    localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = $clog2(DIGITS);

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     active_q, active_d;
    logic [DW-1:0]     shadow_q, shadow_d;
    logic              full_q, full_d;
    logic              frame_d;
    logic              err_d;
    logic [3:0]        bcd_d;
    logic [DIGITS-1:0] sel_d;
    logic              accept_c;
    logic [3:0]        nib_c;
    logic              blank_c;
`ifdef LEADING_ZERO_BLANK_EN
    logic              hi_zero_c;
`endif

    // Next-state, handshake and display decode; outputs follow the next state so they
    // line up with the registered state in every cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        active_d = active_q;
        shadow_d = shadow_q;
        full_d   = full_q;
        frame_d  = 1'b0;
        err_d    = bus.err_o;
        bcd_d    = 4'd0;
        sel_d    = '1;
        nib_c    = 4'd0;
        blank_c  = 1'b0;
        accept_c = bus.load_valid_i & bus.load_ready_o;
`ifdef LEADING_ZERO_BLANK_EN
        hi_zero_c = 1'b1;
`endif

        if (accept_c) begin
            shadow_d = bus.load_data_i;
            full_d   = 1'b1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (bus.load_data_i[4*i +: 4] > 4'd9) err_d = 1'b1;
            end
        end

        case (state_q)
            ST_GAP: begin
                if (GAP == 0 || cnt_q == CW'(GAP - 1)) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_d   = '0;
                    state_d = (GAP == 0) ? ST_ON : ST_GAP;
                    if (idx_q == IW'(DIGITS - 1)) begin
                        idx_d   = '0;
                        frame_d = 1'b1;
                        // Frame boundary: the only place a pending value becomes visible.
                        if (full_q) begin
                            active_d = shadow_q;
                            full_d   = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_GAP;
        endcase

        if (state_d == ST_ON) begin
            nib_c   = active_d[{idx_d, 2'b00} +: 4];
            blank_c = (nib_c > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
            for (int unsigned j = 0; j < DIGITS; j++) begin
                if (j >= 32'(idx_d) && active_d[4*j +: 4] != 4'd0) hi_zero_c = 1'b0;
            end
            if (idx_d != '0 && hi_zero_c) blank_c = 1'b1;
`endif
            if (!blank_c) begin
                sel_d[idx_d] = 1'b0;
                bcd_d        = nib_c;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= ST_GAP;
            cnt_q            <= '0;
            idx_q            <= '0;
            active_q         <= '0;
            shadow_q         <= '0;
            full_q           <= 1'b0;
            bus.load_ready_o <= 1'b1;
            bus.frame_o      <= 1'b0;
            bus.err_o        <= 1'b0;
            bus.bcd_o        <= 4'd0;
            bus.dig_sel_o    <= '1;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            idx_q            <= idx_d;
            active_q         <= active_d;
            shadow_q         <= shadow_d;
            full_q           <= full_d;
            bus.load_ready_o <= ~full_d;
            bus.frame_o      <= frame_d;
            bus.err_o        <= err_d;
            bus.bcd_o        <= bcd_d;
            bus.dig_sel_o    <= sel_d;
        end
    end
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: timeline reference model plus a shadow-value queue scoreboard,
// checking a GAP=1 instance under load traffic and an idle GAP=0 instance every cycle.
module tb_digit_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DWELL  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_scan_ctrl_if #(.DIGITS(DIGITS)) bus1 ();
    digit_scan_ctrl_if #(.DIGITS(DIGITS)) bus0 ();

    digit_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(1)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus1)
    );

    digit_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(0)) dut0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus0)
    );

    assign bus0.load_valid_i = 1'b0;
    assign bus0.load_data_i  = 16'h0000;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: t = cycles since reset release; sh_q holds accepted, uncommitted values.
    int          t = 0;
    logic [15:0] m_active = 16'h0;
    logic        m_err = 1'b0;
    logic        m_ready = 1'b1;
    logic [15:0] sh_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Expected display for cycle t: slots of (gap blank + DWELL lit) per digit.
    function automatic void exp_out(input int tc, input int gap, input logic [15:0] act,
                                    output logic [3:0] sel, output logic [3:0] bcd,
                                    output logic frm);
        int   tt, len, per, pos, d, off;
        logic [3:0] nib;
        logic blank;
        sel = 4'b1111;
        bcd = 4'd0;
        frm = 1'b0;
        len = DWELL + gap;
        per = DIGITS * len;
        tt  = (gap == 0) ? tc - 1 : tc;
        if (tt < 0) return;
        frm = (tt > 0) && (tt % per == 0);
        pos = tt % per;
        d   = pos / len;
        off = pos % len;
        if (off < gap) return;
        nib   = act[4*d +: 4];
        blank = (nib > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0 && (act >> (4*d)) == 16'h0) blank = 1'b1;
`endif
        if (!blank) begin
            sel[d] = 1'b0;
            bcd    = nib;
        end
    endfunction

    // Model update on each clock edge.
    always @(posedge clk or negedge rst_n) begin
        logic        acc;
        logic [15:0] din;
        if (!rst_n) begin
            t        = 0;
            m_active = 16'h0;
            m_err    = 1'b0;
            m_ready  = 1'b1;
            sh_q.delete();
        end else begin
            acc = bus1.load_valid_i && m_ready;
            din = bus1.load_data_i;
            t   = t + 1;
            if (t % (DIGITS * (DWELL + 1)) == 0 && sh_q.size() > 0) m_active = sh_q.pop_front();
            if (acc) begin
                sh_q.push_back(din);
                for (int i = 0; i < DIGITS; i++) if (din[4*i +: 4] > 4'd9) m_err = 1'b1;
            end
            m_ready = (sh_q.size() == 0);
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        logic [3:0] s, b;
        logic       f;
        exp_out(t, 1, m_active, s, b, f);
        chk("sel", 16'(bus1.dig_sel_o), 16'(s));
        chk("bcd", 16'(bus1.bcd_o), 16'(b));
        chk("frame", 16'(bus1.frame_o), 16'(f));
        chk("ready", 16'(bus1.load_ready_o), 16'(m_ready));
        chk("err", 16'(bus1.err_o), 16'(m_err));
        exp_out(t, 0, 16'h0, s, b, f);
        chk("gap0_sel", 16'(bus0.dig_sel_o), 16'(s));
        chk("gap0_bcd", 16'(bus0.bcd_o), 16'(b));
        chk("gap0_frame", 16'(bus0.frame_o), 16'(f));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v, input int cycles);
        bus1.load_valid_i = 1'b1;
        bus1.load_data_i  = v;
        step(cycles);
        bus1.load_valid_i = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        int guard = 0;
        while (t % (DIGITS * (DWELL + 1)) != p && guard < 100) begin
            step(1);
            guard++;
        end
        if (guard >= 100) chk("wait_phase_timeout", 16'(guard), 16'(0));
    endtask

    initial begin
        bus1.load_valid_i = 1'b0;
        bus1.load_data_i  = 16'h0;
        step(2);
        chk("rst_sel", 16'(bus1.dig_sel_o), 16'hF);
        chk("rst_ready", 16'(bus1.load_ready_o), 16'h1);
        rst_n = 1'b1;
        step(27);                        // idle frame, first frame pulse at t=20
        load(16'h1234, 1);               // mid-frame load
        load(16'h5678, 2);               // ignored: shadow full
        wait_phase(2);                   // past commit of 1234
        load(16'h5678, 1);
        step(25);
        load(16'h12A4, 1);               // invalid nibble in digit 1
        step(15);
        load(16'h0000, 1);
        step(30);
        load(16'h0050, 1);
        wait_phase(1);
        load(16'h9999, 1);               // pending when reset hits
        wait_phase(3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_sel", 16'(bus1.dig_sel_o), 16'hF);
        chk("async_bcd", 16'(bus1.bcd_o), 16'h0);
        chk("async_err", 16'(bus1.err_o), 16'h0);
        chk("async_ready", 16'(bus1.load_ready_o), 16'h1);
        step(2);
        rst_n = 1'b1;
        step(45);                        // 9999 must never appear
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
